spi_bulk_engine: RTL and testbench
==================================

// Module: spi_bulk_engine
// PURPOSE
//  SPI mode-0 byte engine with a programmable clock divider and a receive FIFO.
//  Sits directly downstream of the CPU I/O register decoder: the decoder issues
//  start/tx bytes and pops received bytes; this block drives SCK/SDO and samples SDI.
//  In bulk mode it prefetches bytes (transmitting 0xFF) until the FIFO is full, so
//  CPU reads of the SPI data port return immediately.
// PARAMETERS
//  FIFO_DEPTH  4  receive FIFO entries; power of two, >= 2
//  CNT_W       3  FIFO count width = log2(FIFO_DEPTH)+1
// PORTS
//  i_clk          in   1      FPGA clock (100 MHz)
//  i_rst_n        in   1      asynchronous active-low reset
//  i_clk_sel      in   3      half-period select: SCK half-period = 2**i_clk_sel i_clk cycles
//  i_bulk         in   1      1 = auto-prefetch with tx 0xFF while FIFO not full
//  i_start        in   1      one-cycle pulse: begin transfer of i_tx_data
//  i_tx_data      in   8      byte to transmit, sampled on i_start
//  i_rx_pop       in   1      one-cycle pulse: discard FIFO head
//  i_clr          in   1      flush FIFO, clear overflow (does not abort a transfer)
//  o_busy         out  1      transfer in progress
//  o_rx_data      out  8      FIFO head (first-word fall-through); 0xFF when empty
//  o_rx_valid     out  1      FIFO non-empty
//  o_rx_count     out  CNT_W  FIFO occupancy
//  o_rx_overflow  out  1      sticky: completed byte dropped because FIFO full
//  o_sck          out  1      SPI clock, idle low
//  o_sdo          out  1      SPI data out, idle high
//  i_sdi          in   1      SPI data in (already synchronised upstream)
// BEHAVIOUR
//  Reset (async, any time incl. mid-byte): o_busy=0, o_sck=0, o_sdo=1, FIFO empty,
//   o_rx_count=0, o_rx_valid=0, o_rx_data=0xFF, o_rx_overflow=0, FSM IDLE.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: i_start=1 -> load tx shift reg = i_tx_data, latch i_clk_sel, divider=0,
//    bit=0, SHIFT. Else if i_bulk=1 and FIFO count + 0 < FIFO_DEPTH -> same with
//    tx=0xFF. i_start has priority over bulk prefetch.
//   SHIFT: o_busy=1; o_sdo = tx[7]. Divider counts 0..2**sel-1; on wrap toggle SCK.
//    Rising edge: shift i_sdi into rx LSB. Falling edge: tx <= {tx[6:0],1'b1}; after
//    8th falling edge -> DONE. One byte = 16 * 2**sel cycles of SHIFT.
//   DONE (1 cycle): push rx byte; o_busy=0 next cycle; -> IDLE.
//  o_busy rises the cycle after i_start; i_start while o_busy=1 ignored (no queue).
//  i_clk_sel changes mid-byte have no effect until the next transfer.
//  Bulk never starts when FIFO full; it resumes the cycle after a pop frees a slot.
//  Push when full: byte dropped, o_rx_overflow<=1 (only reachable via i_start).
//  Simultaneous push and pop: both take effect, count unchanged (also when full).
//  Pop when empty: ignored. i_clr same cycle as push: FIFO ends empty, overflow 0.
//  Pointers wrap modulo FIFO_DEPTH; count is exact 0..FIFO_DEPTH.
//  Clearing i_bulk mid-byte completes the current byte; no further prefetch.
// TESTING
//  1. Reset, sel=0, start tx=0xA5, SDI loopback -> 16-cycle SHIFT, SDO bits 1,0,1,0,
//     0,1,0,1, FIFO head 0xA5, count 1, busy high exactly 16 cycles + DONE.
//  2. sel=3, start tx=0x3C, SDI tied 0 -> SCK half-period 8 cycles, byte 128 cycles,
//     head 0x00; change sel to 0 mid-byte -> timing unchanged.
//  3. bulk=1, SDI tied 1, no pops -> exactly 4 prefetches with SDO constantly 1,
//     count 4, engine idle; one pop -> one more transfer, count returns to 4.
//  4. FIFO full (bulk=0), start tx=0x55 -> byte dropped, overflow=1, count 4;
//     i_clr -> count 0, overflow 0, o_rx_data 0xFF.
//  5. Push and pop same cycle with count 4 -> count stays 4, head advances in order.
//  6. Assert i_rst_n low at bit 3 of a transfer -> SCK 0, SDO 1, busy 0, FIFO empty
//     immediately; next start completes a clean byte.

Source files
------------

// File: rtl/spi_bulk_engine_if.sv
// Register-decoder handshake and SPI pin bundle for spi_bulk_engine.
// The master side is the CPU decoder (and pad logic for i_sdi); the slave side is the engine.
interface spi_bulk_engine_if #(
  parameter int CNT_W = 3
);
  logic [2:0]       i_clk_sel;
  logic             i_bulk;
  logic             i_start;
  logic [7:0]       i_tx_data;
  logic             i_rx_pop;
  logic             i_clr;
  logic             o_busy;
  logic [7:0]       o_rx_data;
  logic             o_rx_valid;
  logic [CNT_W-1:0] o_rx_count;
  logic             o_rx_overflow;
  logic             o_sck;
  logic             o_sdo;
  logic             i_sdi;

  modport master (
    output i_clk_sel, i_bulk, i_start, i_tx_data, i_rx_pop, i_clr, i_sdi,
    input  o_busy, o_rx_data, o_rx_valid, o_rx_count, o_rx_overflow, o_sck, o_sdo
  );

  modport slave (
    input  i_clk_sel, i_bulk, i_start, i_tx_data, i_rx_pop, i_clr, i_sdi,
    output o_busy, o_rx_data, o_rx_valid, o_rx_count, o_rx_overflow, o_sck, o_sdo
  );
endinterface

// File: rtl/spi_bulk_engine.sv
// SPI mode-0 byte engine: programmable SCK divider, bulk 0xFF prefetch and a
// first-word-fall-through receive FIFO read by the CPU data port.
module spi_bulk_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input logic              i_clk,
  input logic              i_rst_n,
  spi_bulk_engine_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic             busy_q, sck_q;
  logic [7:0]       tx_q, rx_q;
  logic [6:0]       div_q, div_max;
  logic [2:0]       sel_q, bit_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic             room, push, pop, push_ok;

  assign div_max = 7'((8'd1 << sel_q) - 8'd1);
  assign room    = cnt_q < CNT_W'(FIFO_DEPTH);
  assign push    = state_q == DONE;

  // tx_q refills with ones, so it idles at 0xFF and tx_q[7] doubles as the idle-high SDO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      tx_q    <= 8'hFF;
      rx_q    <= 8'h00;
      div_q   <= '0;
      sel_q   <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start || (bus.i_bulk && room)) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            tx_q    <= bus.i_start ? bus.i_tx_data : 8'hFF;
            sel_q   <= bus.i_clk_sel;
            div_q   <= '0;
            bit_q   <= '0;
          end
        end
        SHIFT: begin
          if (div_q == div_max) begin
            div_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              rx_q <= {rx_q[6:0], bus.i_sdi};
            end else begin
              tx_q  <= {tx_q[6:0], 1'b1};
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= DONE;
            end
          end else begin
            div_q <= div_q + 7'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pop is evaluated first so a push into a full FIFO still lands when a slot frees that cycle.
  always_comb begin
    pop     = bus.i_rx_pop && (cnt_q != '0);
    push_ok = push && (room || pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (bus.i_clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop)     rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
      if (push && !push_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !bus.i_clr) mem[wr_q] <= rx_q;
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_sck         = sck_q;
  assign bus.o_sdo         = tx_q[7];
  assign bus.o_rx_count    = cnt_q;
  assign bus.o_rx_valid    = cnt_q != '0;
  assign bus.o_rx_data     = (cnt_q != '0) ? mem[rd_q] : 8'hFF;
  assign bus.o_rx_overflow = ovf_q;
endmodule

// File: tb/tb_spi_bulk_engine.sv
// Bench for spi_bulk_engine: cycle model of transfers/FIFO checked every cycle,
// plus directed scenarios with literal expectations.
module tb_spi_bulk_engine;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   sdi_mode = 1;  // 0: tie low, 1: tie high, 2: loopback from SDO

  spi_bulk_engine_if #(.CNT_W(3)) bus ();

  spi_bulk_engine #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  assign bus.i_sdi = (sdi_mode == 2) ? bus.o_sdo : sdi_mode[0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transfer is an offset k into a (16*H + 1)-cycle window; outputs follow
  // arithmetically from k, H and the byte. FIFO is a queue.
  logic       m_act;
  int         m_k, m_h;
  logic [7:0] m_tx, m_rx;
  logic [7:0] m_q[$];
  logic       m_ovf;

  task automatic model_reset();
    m_act = 1'b0;
    m_k   = 0;
    m_h   = 1;
    m_tx  = 8'hFF;
    m_rx  = 8'h00;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int   sz;
    logic done;
    sz   = m_q.size();
    done = m_act && (m_k == 16 * m_h);
    if (bus.i_clr) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (bus.i_rx_pop && sz > 0) void'(m_q.pop_front());
      if (done) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_rx);
        else m_ovf = 1'b1;
      end
    end
    if (m_act) begin
      if (done) m_act = 1'b0;
      else m_k++;
    end else if (bus.i_start || (bus.i_bulk && sz < DEPTH)) begin
      m_act = 1'b1;
      m_k   = 0;
      m_h   = 1 << bus.i_clk_sel;
      m_tx  = bus.i_start ? bus.i_tx_data : 8'hFF;
      m_rx  = (sdi_mode == 2) ? m_tx : ((sdi_mode == 1) ? 8'hFF : 8'h00);
    end
  endtask

  function automatic logic e_sck();
    return m_act && (m_k < 16 * m_h) && (((m_k / m_h) % 2) == 1);
  endfunction

  function automatic logic e_sdo();
    if (m_act && (m_k < 16 * m_h)) return m_tx[7 - m_k / (2 * m_h)];
    return 1'b1;
  endfunction

  function automatic logic [7:0] e_data();
    if (m_q.size() > 0) return m_q[0];
    return 8'hFF;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_busy",  bus.o_busy,        m_act);
      chk("cyc_sck",   bus.o_sck,         e_sck());
      chk("cyc_sdo",   bus.o_sdo,         e_sdo());
      chk("cyc_count", bus.o_rx_count,    m_q.size());
      chk("cyc_valid", bus.o_rx_valid,    m_q.size() > 0);
      chk("cyc_data",  bus.o_rx_data,     e_data());
      chk("cyc_ovf",   bus.o_rx_overflow, m_ovf);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [7:0] d, input logic [2:0] s);
    @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_tx_data = d;
    bus.i_clk_sel = s;
    @(negedge clk);
    bus.i_start   = 1'b0;
  endtask

  task automatic pulse_pop();
    @(negedge clk);
    bus.i_rx_pop = 1'b1;
    @(negedge clk);
    bus.i_rx_pop = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.i_clr = 1'b1;
    @(negedge clk);
    bus.i_clr = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; an expired budget shows as busy still high.
  task automatic wait_idle(input int budget, output int nb);
    nb = 0;
    while (bus.o_busy && nb < budget) begin
      nb++;
      @(negedge clk);
    end
    chk("idle_timeout", bus.o_busy, 1'b0);
  endtask

  initial begin
    int         nb, hi, rises;
    logic       prev, zero_seen;
    logic [7:0] cap;
    logic [7:0] exp_seq [3];

    bus.i_clk_sel = 3'd0;
    bus.i_bulk    = 1'b0;
    bus.i_start   = 1'b0;
    bus.i_tx_data = 8'h00;
    bus.i_rx_pop  = 1'b0;
    bus.i_clr     = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  bus.o_busy,        1'b0);
    chk("rst_sck",   bus.o_sck,         1'b0);
    chk("rst_sdo",   bus.o_sdo,         1'b1);
    chk("rst_count", bus.o_rx_count,    3'd0);
    chk("rst_data",  bus.o_rx_data,     8'hFF);
    chk("rst_ovf",   bus.o_rx_overflow, 1'b0);
    rst_n = 1'b1;

    // 1: loopback byte at sel=0
    sdi_mode = 2;
    do_start(8'hA5, 3'd0);
    nb = 0; cap = 8'h00; prev = 1'b0;
    while (bus.o_busy && nb < 60) begin
      nb++;
      if (bus.o_sck && !prev) cap = {cap[6:0], bus.o_sdo};
      prev = bus.o_sck;
      @(negedge clk);
    end
    chk("t1_busy_cycles", nb, 17);
    chk("t1_sdo_bits",    cap, 8'hA5);
    chk("t1_head",        bus.o_rx_data, 8'hA5);
    chk("t1_count",       bus.o_rx_count, 3'd1);

    // 2: sel=3, SDI low, sel changed mid-byte
    sdi_mode = 0;
    do_start(8'h3C, 3'd3);
    nb = 0; hi = 0;
    while (bus.o_busy && nb < 300) begin
      nb++;
      if (nb == 20) bus.i_clk_sel = 3'd0;
      if (bus.o_sck) hi++;
      @(negedge clk);
    end
    chk("t2_busy_cycles", nb, 129);
    chk("t2_sck_high",    hi, 64);
    chk("t2_count",       bus.o_rx_count, 3'd2);
    pulse_pop();
    chk("t2_head",        bus.o_rx_data, 8'h00);
    pulse_clr();

    // 3: bulk prefetch until full, then one refill after a pop
    sdi_mode = 1;
    @(negedge clk);
    bus.i_bulk = 1'b1;
    rises = 0; prev = 1'b0; zero_seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.o_busy && !prev) rises++;
      if (!bus.o_sdo) zero_seen = 1'b1;
      prev = bus.o_busy;
    end
    chk("t3_prefetches", rises, 4);
    chk("t3_sdo_ones",   zero_seen, 1'b0);
    chk("t3_count",      bus.o_rx_count, 3'd4);
    chk("t3_idle",       bus.o_busy, 1'b0);
    pulse_pop();
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.o_busy && !prev) rises++;
      prev = bus.o_busy;
      @(negedge clk);
    end
    chk("t3_refill",       rises, 1);
    chk("t3_count_refill", bus.o_rx_count, 3'd4);
    bus.i_bulk = 1'b0;

    // 4: push into full FIFO overflows; clear recovers
    sdi_mode = 2;
    do_start(8'h55, 3'd0);
    wait_idle(60, nb);
    chk("t4_ovf",   bus.o_rx_overflow, 1'b1);
    chk("t4_count", bus.o_rx_count, 3'd4);
    chk("t4_head",  bus.o_rx_data, 8'hFF);
    pulse_clr();
    chk("t4_clr_count", bus.o_rx_count, 3'd0);
    chk("t4_clr_ovf",   bus.o_rx_overflow, 1'b0);
    chk("t4_clr_data",  bus.o_rx_data, 8'hFF);

    // 5: push and pop in the same cycle while full
    do_start(8'h11, 3'd0); wait_idle(60, nb);
    do_start(8'h22, 3'd0); wait_idle(60, nb);
    do_start(8'h33, 3'd0); wait_idle(60, nb);
    do_start(8'h44, 3'd0); wait_idle(60, nb);
    chk("t5_full", bus.o_rx_count, 3'd4);
    do_start(8'h55, 3'd0);
    repeat (16) @(negedge clk);
    bus.i_rx_pop = 1'b1;
    @(negedge clk);
    bus.i_rx_pop = 1'b0;
    chk("t5_count", bus.o_rx_count, 3'd4);
    chk("t5_ovf",   bus.o_rx_overflow, 1'b0);
    exp_seq[0] = 8'h22; exp_seq[1] = 8'h33; exp_seq[2] = 8'h44;
    for (int j = 0; j < 3; j++) begin
      chk("t5_order", bus.o_rx_data, exp_seq[j]);
      pulse_pop();
    end
    chk("t5_last",  bus.o_rx_data, 8'h55);
    chk("t5_left",  bus.o_rx_count, 3'd1);

    // 6: async reset in the middle of bit 3 while SCK is high
    do_start(8'hC3, 3'd1);
    repeat (14) @(negedge clk);
    chk("t6_sck_pre", bus.o_sck, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sck",   bus.o_sck, 1'b0);
    chk("t6_sdo",   bus.o_sdo, 1'b1);
    chk("t6_busy",  bus.o_busy, 1'b0);
    chk("t6_count", bus.o_rx_count, 3'd0);
    chk("t6_valid", bus.o_rx_valid, 1'b0);
    chk("t6_data",  bus.o_rx_data, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(8'h96, 3'd0);
    wait_idle(60, nb);
    chk("t6_busy_cycles", nb, 17);
    chk("t6_head",        bus.o_rx_data, 8'h96);
    chk("t6_count_after", bus.o_rx_count, 3'd1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
